// File: rtl/esp32_uart.sv
// Byte-level 8N1 UART engine: TX FIFO feeding a serialiser, RX deserialiser feeding an RX FIFO.
// Bit period comes from a runtime prescaler, latched at the start of every frame.
`timescale 1ns/1ps

module esp32_uart #(
    parameter int unsigned PRESC_W  = 17,
    parameter int unsigned TX_DEPTH = 16,
    parameter int unsigned RX_DEPTH = 64
) (
    input  logic               clk_peripheral,
    input  logic               resetn,
    input  logic [PRESC_W-1:0] prescaler,
    input  logic [7:0]         tx_data,
    input  logic               tx_valid,
    output logic               tx_ready,
    output logic [7:0]         rx_data,
    output logic               rx_valid,
    input  logic               rx_ready,
    output logic               rx_overflow,
    output logic               rx_frame_err,
    input  logic               err_clr,
    output logic               tx_busy,
    output logic               uart_tx,
    input  logic               uart_rx
);

    localparam int unsigned TX_AW = $clog2(TX_DEPTH);
    localparam int unsigned RX_AW = $clog2(RX_DEPTH);
    localparam logic [PRESC_W-1:0] PMin = PRESC_W'(4);
    localparam logic [PRESC_W-1:0] POne = PRESC_W'(1);

    typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;
    typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxStop, RxBreak} rx_state_e;

    logic [PRESC_W-1:0] p_eff;

    assign p_eff = (prescaler < PMin) ? PMin : prescaler;

    // ---------------------------------------------------------------- TX FIFO
    logic [7:0]     tx_mem [TX_DEPTH];
    logic [TX_AW:0] tx_wptr_q, tx_wptr_d;
    logic [TX_AW:0] tx_rptr_q, tx_rptr_d;
    logic           tx_full, tx_empty, tx_push, tx_pop;
    logic [7:0]     tx_head;

    assign tx_full  = (tx_wptr_q[TX_AW-1:0] == tx_rptr_q[TX_AW-1:0]) &&
                      (tx_wptr_q[TX_AW] != tx_rptr_q[TX_AW]);
    assign tx_empty = (tx_wptr_q == tx_rptr_q);
    assign tx_push  = tx_valid && !tx_full;
    assign tx_head  = tx_mem[tx_rptr_q[TX_AW-1:0]];

    always_comb begin
        tx_wptr_d = tx_wptr_q + (TX_AW+1)'(tx_push);
        tx_rptr_d = tx_rptr_q + (TX_AW+1)'(tx_pop);
    end

    always_ff @(posedge clk_peripheral) begin
        if (tx_push) begin
            tx_mem[tx_wptr_q[TX_AW-1:0]] <= tx_data;
        end
    end

    // ---------------------------------------------------------------- TX FSM
    tx_state_e          tx_state_q, tx_state_d;
    logic [PRESC_W-1:0] tx_cnt_q, tx_cnt_d;
    logic [PRESC_W-1:0] tx_per_q, tx_per_d;
    logic [2:0]         tx_bit_q, tx_bit_d;
    logic [7:0]         tx_shift_q, tx_shift_d;
    logic               uart_tx_q, uart_tx_d;
    logic               tx_bit_end;

    assign tx_bit_end = (tx_cnt_q == tx_per_q - POne);

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_bit_end ? '0 : tx_cnt_q + POne;
        tx_per_d   = tx_per_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_pop     = 1'b0;
        case (tx_state_q)
            TxIdle: begin
                tx_cnt_d = '0;
                if (!tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_shift_d = tx_head;
                    tx_per_d   = p_eff;
                    tx_state_d = TxStart;
                end
            end
            TxStart: begin
                if (tx_bit_end) begin
                    tx_bit_d   = 3'd0;
                    tx_state_d = TxData;
                end
            end
            TxData: begin
                if (tx_bit_end) begin
                    tx_shift_d = {1'b1, tx_shift_q[7:1]};
                    tx_bit_d   = tx_bit_q + 3'd1;
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = TxStop;
                    end
                end
            end
            TxStop: begin
                if (tx_bit_end) begin
                    // Back-to-back frames reload straight into START with a fresh prescaler.
                    if (!tx_empty) begin
                        tx_pop     = 1'b1;
                        tx_shift_d = tx_head;
                        tx_per_d   = p_eff;
                        tx_state_d = TxStart;
                    end else begin
                        tx_state_d = TxIdle;
                    end
                end
            end
            default: tx_state_d = TxIdle;
        endcase

        case (tx_state_q)
            TxStart: uart_tx_d = 1'b0;
            TxData:  uart_tx_d = tx_shift_q[0];
            default: uart_tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk_peripheral or negedge resetn) begin
        if (!resetn) begin
            tx_wptr_q  <= '0;
            tx_rptr_q  <= '0;
            tx_state_q <= TxIdle;
            tx_cnt_q   <= '0;
            tx_per_q   <= PMin;
            tx_bit_q   <= 3'd0;
            tx_shift_q <= 8'hff;
            uart_tx_q  <= 1'b1;
        end else begin
            tx_wptr_q  <= tx_wptr_d;
            tx_rptr_q  <= tx_rptr_d;
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_per_q   <= tx_per_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            uart_tx_q  <= uart_tx_d;
        end
    end

    // ---------------------------------------------------------------- RX front end + FSM
    logic               rx_sync1_q, rx_sync2_q;
    logic               rxs;
    rx_state_e          rx_state_q, rx_state_d;
    logic [PRESC_W-1:0] rx_cnt_q, rx_cnt_d;
    logic [PRESC_W-1:0] rx_per_q, rx_per_d;
    logic [2:0]         rx_bit_q, rx_bit_d;
    logic [7:0]         rx_shift_q, rx_shift_d;
    logic               rx_bit_end, rx_half_end;
    logic               rx_push, rx_ferr_set;

    assign rxs         = rx_sync2_q;
    assign rx_bit_end  = (rx_cnt_q == rx_per_q - POne);
    assign rx_half_end = (rx_cnt_q == (rx_per_q >> 1) - POne);

    always_comb begin
        rx_state_d  = rx_state_q;
        rx_cnt_d    = rx_cnt_q + POne;
        rx_per_d    = rx_per_q;
        rx_bit_d    = rx_bit_q;
        rx_shift_d  = rx_shift_q;
        rx_push     = 1'b0;
        rx_ferr_set = 1'b0;
        case (rx_state_q)
            RxIdle: begin
                rx_cnt_d = '0;
                if (!rxs) begin
                    rx_per_d   = p_eff;
                    rx_state_d = RxStart;
                end
            end
            RxStart: begin
                // Mid start bit: a line already back high was only a glitch.
                if (rx_half_end) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = 3'd0;
                    rx_state_d = rxs ? RxIdle : RxData;
                end
            end
            RxData: begin
                if (rx_bit_end) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rxs, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = RxStop;
                    end
                end
            end
            RxStop: begin
                if (rx_bit_end) begin
                    rx_cnt_d = '0;
                    if (rxs) begin
                        rx_push    = 1'b1;
                        rx_state_d = RxIdle;
                    end else begin
                        rx_ferr_set = 1'b1;
                        rx_state_d  = RxBreak;
                    end
                end
            end
            RxBreak: begin
                rx_cnt_d = '0;
                if (rxs) begin
                    rx_state_d = RxIdle;
                end
            end
            default: rx_state_d = RxIdle;
        endcase
    end

    // ---------------------------------------------------------------- RX FIFO + flags
    logic [7:0]     rx_mem [RX_DEPTH];
    logic [RX_AW:0] rx_wptr_q, rx_wptr_d;
    logic [RX_AW:0] rx_rptr_q, rx_rptr_d;
    logic           rx_full, rx_empty, rx_pop, rx_wr, rx_ovf_set;
    logic           rx_ovf_q, rx_ovf_d;
    logic           rx_ferr_q, rx_ferr_d;

    assign rx_full    = (rx_wptr_q[RX_AW-1:0] == rx_rptr_q[RX_AW-1:0]) &&
                        (rx_wptr_q[RX_AW] != rx_rptr_q[RX_AW]);
    assign rx_empty   = (rx_wptr_q == rx_rptr_q);
    assign rx_pop     = rx_ready && !rx_empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign rx_wr      = rx_push && (!rx_full || rx_pop);
    assign rx_ovf_set = rx_push && rx_full && !rx_pop;

    always_comb begin
        rx_wptr_d = rx_wptr_q + (RX_AW+1)'(rx_wr);
        rx_rptr_d = rx_rptr_q + (RX_AW+1)'(rx_pop);
        rx_ovf_d  = (rx_ovf_q && !err_clr) || rx_ovf_set;
        rx_ferr_d = (rx_ferr_q && !err_clr) || rx_ferr_set;
    end

    always_ff @(posedge clk_peripheral) begin
        if (rx_wr) begin
            rx_mem[rx_wptr_q[RX_AW-1:0]] <= rx_shift_q;
        end
    end

    always_ff @(posedge clk_peripheral or negedge resetn) begin
        if (!resetn) begin
            rx_sync1_q <= 1'b1;
            rx_sync2_q <= 1'b1;
            rx_state_q <= RxIdle;
            rx_cnt_q   <= '0;
            rx_per_q   <= PMin;
            rx_bit_q   <= 3'd0;
            rx_shift_q <= 8'h00;
            rx_wptr_q  <= '0;
            rx_rptr_q  <= '0;
            rx_ovf_q   <= 1'b0;
            rx_ferr_q  <= 1'b0;
        end else begin
            rx_sync1_q <= uart_rx;
            rx_sync2_q <= rx_sync1_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_per_q   <= rx_per_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_wptr_q  <= rx_wptr_d;
            rx_rptr_q  <= rx_rptr_d;
            rx_ovf_q   <= rx_ovf_d;
            rx_ferr_q  <= rx_ferr_d;
        end
    end

    // ---------------------------------------------------------------- outputs
    assign tx_ready     = !tx_full;
    assign tx_busy      = !tx_empty || (tx_state_q != TxIdle);
    assign uart_tx      = uart_tx_q;
    assign rx_valid     = !rx_empty;
    assign rx_data      = rx_empty ? 8'h00 : rx_mem[rx_rptr_q[RX_AW-1:0]];
    assign rx_overflow  = rx_ovf_q;
    assign rx_frame_err = rx_ferr_q;

endmodule

// File: tb/tb_esp32_uart.sv
// Randomised self-checking bench for esp32_uart: a bench-side UART transmitter/receiver
// and byte queues act as the reference for both serial directions.
`timescale 1ns/1ps

module tb_esp32_uart;

    logic        clk_peripheral = 1'b0;
    logic        resetn = 1'b0;
    logic [16:0] prescaler = 17'd8;
    logic [7:0]  tx_data = 8'h00;
    logic        tx_valid = 1'b0;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready = 1'b0;
    logic        rx_overflow;
    logic        rx_frame_err;
    logic        err_clr = 1'b0;
    logic        tx_busy;
    logic        uart_tx;
    logic        uart_rx = 1'b1;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] txq[$];
    logic [7:0] rxq[$];

    esp32_uart dut (
        .clk_peripheral (clk_peripheral),
        .resetn         (resetn),
        .prescaler      (prescaler),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .rx_ready       (rx_ready),
        .rx_overflow    (rx_overflow),
        .rx_frame_err   (rx_frame_err),
        .err_clr        (err_clr),
        .tx_busy        (tx_busy),
        .uart_tx        (uart_tx),
        .uart_rx        (uart_rx)
    );

    always #5 clk_peripheral = ~clk_peripheral;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_peripheral);
        #1;
    endtask

    function automatic int eff_p(input int raw);
        return (raw < 4) ? 4 : raw;
    endfunction

    task automatic push_tx(input logic [7:0] b);
        int guard = 0;
        tx_data  = b;
        tx_valid = 1'b1;
        while (!tx_ready && guard < 5000) begin
            tick(1);
            guard++;
        end
        if (!tx_ready) check_eq("tx_accept_timeout", tx_ready, 1);
        tick(1);
        tx_valid = 1'b0;
    endtask

    // Bench UART receiver on uart_tx: find the start bit, then sample mid-bit.
    task automatic tx_recv(input int p, input string tag, output logic [7:0] b);
        int guard = 0;
        b = 8'h00;
        while (uart_tx !== 1'b0 && guard < 12 * p + 100) begin
            tick(1);
            guard++;
        end
        if (uart_tx !== 1'b0) begin
            check_eq({tag, "_timeout"}, uart_tx, 0);
            return;
        end
        tick(p / 2);
        check_eq({tag, "_startbit"}, uart_tx, 0);
        for (int i = 0; i < 8; i++) begin
            tick(p);
            b[i] = uart_tx;
        end
        tick(p);
        check_eq({tag, "_stopbit"}, uart_tx, 1);
    endtask

    task automatic tx_send_check(input string tag, input logic [7:0] bytes[$], input int p);
        fork
            begin
                for (int i = 0; i < bytes.size(); i++) push_tx(bytes[i]);
            end
            begin
                logic [7:0] got;
                for (int i = 0; i < bytes.size(); i++) begin
                    tx_recv(p, tag, got);
                    check_eq({tag, "_data"}, got, bytes[i]);
                end
            end
        join
    endtask

    // Compare uart_tx cycle by cycle against back-to-back 8N1 frames starting now.
    task automatic tx_wave_check(input string tag, input logic [7:0] bytes[$], input int p,
                                 input int ncyc);
        int mism = 0;
        logic e;
        for (int c = 0; c < ncyc; c++) begin
            int f = c / (10 * p);
            int k = (c % (10 * p)) / p;
            if (f >= bytes.size()) e = 1'b1;
            else if (k == 0)       e = 1'b0;
            else if (k == 9)       e = 1'b1;
            else                   e = bytes[f][k-1];
            if (uart_tx !== e) mism++;
            tick(1);
        end
        check_eq(tag, mism, 0);
    endtask

    // Bench UART transmitter on uart_rx.
    task automatic rx_send(input logic [7:0] b, input int p, input logic stop);
        uart_rx = 1'b0;
        tick(p);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            tick(p);
        end
        uart_rx = stop;
        tick(p);
        uart_rx = 1'b1;
    endtask

    task automatic rx_drain(input string tag);
        logic [7:0] exp;
        while (rxq.size() > 0) begin
            exp = rxq.pop_front();
            check_eq({tag, "_valid"}, rx_valid, 1);
            check_eq({tag, "_data"}, rx_data, exp);
            rx_ready = 1'b1;
            tick(1);
            rx_ready = 1'b0;
        end
        check_eq({tag, "_empty"}, rx_valid, 0);
    endtask

    task automatic pulse_err_clr();
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] q[$];
        logic [7:0] got;
        int acc, hi, lows, p;

        // Reset state
        tick(3);
        check_eq("rst_uart_tx", uart_tx, 1);
        check_eq("rst_tx_ready", tx_ready, 1);
        check_eq("rst_rx_valid", rx_valid, 0);
        check_eq("rst_rx_data", rx_data, 0);
        check_eq("rst_overflow", rx_overflow, 0);
        check_eq("rst_frame_err", rx_frame_err, 0);
        check_eq("rst_tx_busy", tx_busy, 0);
        resetn = 1'b1;
        tick(2);

        // Single frame 0xA5 at P=8: latency, waveform, busy fall
        prescaler = 17'd8;
        push_tx(8'hA5);
        tick(1);
        check_eq("tx_lat_n1", uart_tx, 1);
        tick(1);
        check_eq("tx_lat_n2", uart_tx, 0);
        q = '{8'hA5};
        tx_wave_check("tx_a5_wave", q, 8, 78);
        check_eq("tx_busy_n80", tx_busy, 1);
        tick(1);
        check_eq("tx_busy_n81", tx_busy, 0);
        check_eq("tx_idle_line", uart_tx, 1);
        tick(5);

        // Back-to-back at P=4
        prescaler = 17'd4;
        tx_valid = 1'b1;
        tx_data = 8'h00; tick(1);
        tx_data = 8'hFF; tick(1);
        tx_data = 8'h55; tick(1);
        tx_valid = 1'b0;
        q = '{8'h00, 8'hFF, 8'h55};
        tx_wave_check("tx_b2b_wave", q, 4, 130);
        check_eq("tx_b2b_busy", tx_busy, 0);

        // Prescaler below 4 behaves as 4
        prescaler = 17'd1;
        q = '{8'h3A};
        tx_send_check("tx_presc1", q, 4);
        tick(10);

        // FIFO full: 17 accepts (one already popped), then no more, nothing lost
        prescaler = 17'd20;
        txq = {};
        acc = 0;
        fork
            begin
                tx_valid = 1'b1;
                while (tx_ready && acc < 40) begin
                    tx_data = 8'($urandom);
                    txq.push_back(tx_data);
                    tick(1);
                    acc++;
                end
                check_eq("tx_fill_count", acc, 17);
                tx_data = 8'hEE;
                hi = 0;
                for (int i = 0; i < 30; i++) begin
                    if (tx_ready) hi++;
                    tick(1);
                end
                check_eq("tx_full_hold", hi, 0);
                tx_valid = 1'b0;
            end
            begin
                for (int i = 0; i < 17; i++) begin
                    tx_recv(20, "tx_fill", got);
                    check_eq("tx_fill_data", got, txq.size() > 0 ? txq.pop_front() : 8'h00);
                end
            end
        join
        tick(20);
        check_eq("tx_fill_drained", tx_busy, 0);

        // Random TX rounds
        for (int r = 0; r < 3; r++) begin
            p = $urandom_range(0, 12);
            prescaler = 17'(p);
            q = {};
            for (int i = 0; i < 4; i++) q.push_back(8'($urandom));
            tx_send_check("tx_rand", q, eff_p(p));
            tick(eff_p(p) + 4);
        end

        // Prescaler change mid-frame
        prescaler = 17'd8;
        q = '{8'h96};
        fork
            tx_send_check("tx_pchg_old", q, 8);
            begin
                tick(30);
                prescaler = 17'd16;
            end
        join
        tick(10);
        q = '{8'h69};
        tx_send_check("tx_pchg_new", q, 16);
        tick(20);

        // Reset mid-frame: line high at once and stays high
        prescaler = 17'd8;
        push_tx(8'hC3);
        tick(20);
        resetn = 1'b0;
        #2;
        check_eq("rst_async_tx", uart_tx, 1);
        tick(2);
        check_eq("rst_mid_busy", tx_busy, 0);
        resetn = 1'b1;
        lows = 0;
        for (int i = 0; i < 150; i++) begin
            if (uart_tx !== 1'b1) lows++;
            tick(1);
        end
        check_eq("rst_line_high", lows, 0);

        // RX basic at P=16
        prescaler = 17'd16;
        rx_send(8'h3C, 16, 1'b1);
        tick(4);
        check_eq("rx_3c_valid", rx_valid, 1);
        check_eq("rx_3c_data", rx_data, 8'h3C);
        rx_ready = 1'b1; tick(1); rx_ready = 1'b0;
        check_eq("rx_3c_popped", rx_valid, 0);

        // Glitch
        uart_rx = 1'b0; tick(5); uart_rx = 1'b1;
        tick(40);
        check_eq("rx_glitch_valid", rx_valid, 0);
        check_eq("rx_glitch_ferr", rx_frame_err, 0);

        // Framing error, clear, then recover
        rx_send(8'h12, 16, 1'b0);
        tick(40);
        check_eq("rx_ferr_set", rx_frame_err, 1);
        check_eq("rx_ferr_nopush", rx_valid, 0);
        pulse_err_clr();
        check_eq("rx_ferr_clr", rx_frame_err, 0);
        rx_send(8'h81, 16, 1'b1);
        rxq.push_back(8'h81);
        tick(4);
        rx_drain("rx_after_break");

        // Overflow: 65 bytes with no consumer at P=4
        prescaler = 17'd4;
        for (int i = 0; i < 65; i++) begin
            logic [7:0] b;
            b = 8'($urandom);
            rx_send(b, 4, 1'b1);
            if (i < 64) rxq.push_back(b);
        end
        tick(8);
        check_eq("rx_ovf_set", rx_overflow, 1);
        check_eq("rx_ovf_no_ferr", rx_frame_err, 0);
        rx_drain("rx_ovf");
        pulse_err_clr();
        check_eq("rx_ovf_clr", rx_overflow, 0);

        // RX prescaler change mid-frame
        prescaler = 17'd8;
        fork
            rx_send(8'hB4, 8, 1'b1);
            begin
                tick(20);
                prescaler = 17'd24;
            end
        join
        rxq.push_back(8'hB4);
        tick(8);
        rx_send(8'h4B, 24, 1'b1);
        rxq.push_back(8'h4B);
        tick(16);
        rx_drain("rx_pchg");

        // Random RX rounds
        for (int r = 0; r < 6; r++) begin
            p = $urandom_range(0, 24);
            prescaler = 17'(p);
            for (int i = 0; i < 3; i++) begin
                logic [7:0] b;
                b = 8'($urandom);
                rx_send(b, eff_p(p), 1'b1);
                rxq.push_back(b);
            end
            tick(12);
            rx_drain("rx_rand");
        end
        check_eq("end_ferr", rx_frame_err, 0);
        check_eq("end_ovf", rx_overflow, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
